// File: rtl/tilemap_arbiter_pkg.sv
// rtl/tilemap_arbiter_pkg.sv - shared widths, types and tile codes for the tile-map arbiter
package tilemap_arbiter_pkg;

    localparam int TILE_ADDR_WIDTH = 10;   // 28x36 = 1008 tiles
    localparam int TILE_DATA_WIDTH = 4;

    typedef logic [TILE_ADDR_WIDTH-1:0] tile_addr_t;
    typedef logic [TILE_DATA_WIDTH-1:0] tile_t;

    typedef struct packed {
        tile_addr_t addr;
        tile_t      data;
    } wr_req_t;

    localparam tile_t TILE_EMPTY  = 4'd0;
    localparam tile_t TILE_DOT    = 4'd1;
    localparam tile_t TILE_PELLET = 4'd2;
    localparam tile_t TILE_WALL   = 4'd3;

endpackage

// File: rtl/tilemap_arbiter_if.sv
// rtl/tilemap_arbiter_if.sv - draw/game/RAM bundle shared by the arbiter and its clients
// Ports (slave = arbiter side):
//   display_enabled                        visible-area flag
//   draw_rd_en/addr -> draw_rd_data/valid  drawing pipeline reads, fixed latency
//   game_wr_valid/ready/addr/data          buffered game writes
//   game_rd_req/addr -> game_rd_ack/data   game reads, req/ack
//   wr_fifo_empty                          no pending writes
//   ram_en/we/addr/wdata, ram_rdata        single-port tile RAM
interface tilemap_arbiter_if
    import tilemap_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = TILE_ADDR_WIDTH,
    parameter int DATA_WIDTH = TILE_DATA_WIDTH
) ();
    logic                  display_enabled;
    logic                  draw_rd_en;
    logic [ADDR_WIDTH-1:0] draw_rd_addr;
    logic [DATA_WIDTH-1:0] draw_rd_data;
    logic                  draw_rd_valid;
    logic                  game_wr_valid;
    logic                  game_wr_ready;
    logic [ADDR_WIDTH-1:0] game_wr_addr;
    logic [DATA_WIDTH-1:0] game_wr_data;
    logic                  game_rd_req;
    logic [ADDR_WIDTH-1:0] game_rd_addr;
    logic                  game_rd_ack;
    logic [DATA_WIDTH-1:0] game_rd_data;
    logic                  wr_fifo_empty;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  display_enabled, draw_rd_en, draw_rd_addr,
               game_wr_valid, game_wr_addr, game_wr_data,
               game_rd_req, game_rd_addr, ram_rdata,
        output draw_rd_data, draw_rd_valid, game_wr_ready,
               game_rd_ack, game_rd_data, wr_fifo_empty,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output display_enabled, draw_rd_en, draw_rd_addr,
               game_wr_valid, game_wr_addr, game_wr_data,
               game_rd_req, game_rd_addr, ram_rdata,
        input  draw_rd_data, draw_rd_valid, game_wr_ready,
               game_rd_ack, game_rd_data, wr_fifo_empty,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/tilemap_arbiter_sync_fifo.sv
// rtl/tilemap_arbiter_sync_fifo.sv - first-word-fall-through FIFO with typed payload
// Ports: clk, rst (async, active-high); push/push_data; pop/pop_data (head);
//        full, empty, count (all from the registered count)
module sync_fifo
    import tilemap_arbiter_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wr_req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;   // refused when full even if popping this cycle
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers are exactly PW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tilemap_arbiter.sv
// rtl/tilemap_arbiter.sv - shares the single-port tile RAM between drawing and game logic
// Ports: vga_pix_clk; rst (async, active-high); bus (tilemap_arbiter_if.slave) carrying
//        draw reads, buffered game writes, game req/ack reads and the RAM port.
// Issue order each cycle: draw read, then FIFO head write (blanking only unless
// WR_BLANK_ONLY = 0), then game read (idle and FIFO empty).
module tilemap_arbiter
    import tilemap_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = TILE_ADDR_WIDTH,
    parameter int DATA_WIDTH    = TILE_DATA_WIDTH,
    parameter int FIFO_DEPTH    = 4,
    parameter bit WR_BLANK_ONLY = 1'b1
) (
    input  logic             vga_pix_clk,
    input  logic             rst,
    tilemap_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    typedef enum logic {IDLE, GRD_WAIT} state_t;

    state_t                state;
    req_t                  push_req;
    req_t                  head;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  issue_draw;
    logic                  issue_wr;
    logic                  issue_grd;
    logic                  draw_valid_q;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] grd_data_q;

    assign push_req = {bus.game_wr_addr, bus.game_wr_data};
    assign push     = bus.game_wr_valid && !full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_wr_fifo (
        .clk       (vga_pix_clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (issue_wr),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // The ack cycle is excluded from issuing so a requester that drops req on seeing
    // ack is not served twice; req still high one cycle later is a fresh request.
    always_comb begin
        issue_draw = bus.draw_rd_en;
        issue_wr   = !issue_draw && !empty && (!WR_BLANK_ONLY || !bus.display_enabled);
        issue_grd  = !issue_draw && !issue_wr && empty && (state == IDLE) && !ack_q
                     && bus.game_rd_req;

        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (issue_draw) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.draw_rd_addr;
        end else if (issue_wr) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = head.addr;
            bus.ram_wdata = head.data;
        end else if (issue_grd) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.game_rd_addr;
        end
    end

    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            draw_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            grd_data_q   <= '0;
        end else begin
            draw_valid_q <= issue_draw;
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (issue_grd) state <= GRD_WAIT;
                end
                GRD_WAIT: begin
                    ack_q      <= 1'b1;
                    grd_data_q <= bus.ram_rdata;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM already spends the one cycle of draw latency, so its read data is
    // forwarded in the cycle after issue rather than registered a second time.
    assign bus.draw_rd_valid = draw_valid_q;
    assign bus.draw_rd_data  = draw_valid_q ? bus.ram_rdata : '0;
    assign bus.game_rd_ack   = ack_q;
    assign bus.game_rd_data  = grd_data_q;
    assign bus.game_wr_ready = (count < CW'(FIFO_DEPTH));
    assign bus.wr_fifo_empty = empty;

endmodule

// File: tb/tb_tilemap_arbiter.sv
// tb/tb_tilemap_arbiter.sv - self-checking bench for tilemap_arbiter
module tb_tilemap_arbiter;
    import tilemap_arbiter_pkg::*;

    typedef struct packed {
        logic [9:0] a;
        logic [3:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tilemap_arbiter_if bus ();

    tilemap_arbiter #(
        .FIFO_DEPTH    (4),
        .WR_BLANK_ONLY (1'b1)
    ) dut (
        .vga_pix_clk (clk),
        .rst         (rst),
        .bus         (bus)
    );

    // Tile RAM: one-cycle read latency, write on ram_we.
    logic [3:0] ram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] <= 4'(i);
        forever begin
            @(posedge clk);
            if (bus.ram_en) begin
                if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
                else            bus.ram_rdata     <= ram[bus.ram_addr];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    wr_t        q[$];
    logic [3:0] m_mem [1024];
    bit         m_wait, m_ack, m_dv, m_pushed, saw_ack;
    logic [3:0] m_dd, m_gd, m_grv;
    int         ack_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.draw_rd_en    = 1'b0;
        bus.draw_rd_addr  = '0;
        bus.game_wr_valid = 1'b0;
        bus.game_wr_addr  = '0;
        bus.game_wr_data  = '0;
        bus.game_rd_req   = 1'b0;
        bus.game_rd_addr  = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int         kind;   // 0 none, 1 draw, 2 write, 3 game read
        logic [9:0] da, ga;
        @(negedge clk);
        da = bus.draw_rd_addr;
        ga = bus.game_rd_addr;
        if (bus.draw_rd_en)                                             kind = 1;
        else if (q.size() > 0 && !bus.display_enabled)                  kind = 2;
        else if (!m_wait && !m_ack && q.size() == 0 && bus.game_rd_req) kind = 3;
        else                                                            kind = 0;
        chk("ram_en", bus.ram_en, kind != 0);
        chk("ram_we", bus.ram_we, kind == 2);
        if (kind == 1) chk("ram_addr_draw", bus.ram_addr, da);
        if (kind == 3) chk("ram_addr_game", bus.ram_addr, ga);
        if (kind == 2) begin
            chk("ram_addr_wr", bus.ram_addr, q[0].a);
            chk("ram_wdata", bus.ram_wdata, q[0].d);
        end
        chk("draw_rd_valid", bus.draw_rd_valid, m_dv);
        if (m_dv) chk("draw_rd_data", bus.draw_rd_data, m_dd);
        chk("game_rd_ack", bus.game_rd_ack, m_ack);
        if (m_ack) chk("game_rd_data", bus.game_rd_data, m_gd);
        chk("game_wr_ready", bus.game_wr_ready, q.size() < 4);
        chk("wr_fifo_empty", bus.wr_fifo_empty, q.size() == 0);
        saw_ack = m_ack;
        if (m_ack) ack_count++;

        @(posedge clk);
        m_pushed = bus.game_wr_valid && q.size() < 4;
        if (m_wait) m_gd = m_grv;
        m_ack  = m_wait;
        m_wait = (kind == 3);
        if (kind == 3) m_grv = m_mem[ga];
        m_dv = (kind == 1);
        if (kind == 1) m_dd = m_mem[da];
        if (kind == 2) begin
            m_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (m_pushed) q.push_back('{a: bus.game_wr_addr, d: bus.game_wr_data});
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        q.delete();
        m_wait = 0;
        m_ack  = 0;
        m_dv   = 0;
        #1;
        chk("rst_wr_fifo_empty", bus.wr_fifo_empty, 1'b1);
        chk("rst_game_wr_ready", bus.game_wr_ready, 1'b1);
        chk("rst_game_rd_ack", bus.game_rd_ack, 1'b0);
        chk("rst_draw_rd_valid", bus.draw_rd_valid, 1'b0);
        chk("rst_draw_rd_data", bus.draw_rd_data, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) m_mem[i] = 4'(i);
        rst = 1'b1;
        bus.display_enabled = 1'b1;
        idle_inputs();
        do_reset();
        chk("rst_game_rd_data", bus.game_rd_data, 4'h0);

        // Draw only: 16 back-to-back reads, data = addr[3:0]
        for (int i = 0; i < 16; i++) begin
            bus.draw_rd_en   = 1'b1;
            bus.draw_rd_addr = 10'(i);
            cycle();
        end
        bus.draw_rd_en = 1'b0;
        cycle();

        // Blank-only drain of three writes
        for (int i = 0; i < 3; i++) begin
            bus.game_wr_valid = 1'b1;
            bus.game_wr_addr  = 10'(5 + i);
            bus.game_wr_data  = 4'(1 + i);
            cycle();
        end
        bus.game_wr_valid = 1'b0;
        repeat (2) cycle();
        bus.display_enabled = 1'b0;
        repeat (4) cycle();
        chk("drain_empty", bus.wr_fifo_empty, 1'b1);

        // Full FIFO: fifth write is held until blanking frees an entry
        bus.display_enabled = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.game_wr_valid = 1'b1;
            bus.game_wr_addr  = 10'(20 + k);
            bus.game_wr_data  = 4'(8 + k);
            n = 0;
            do begin
                if (n == 3) bus.display_enabled = 1'b0;
                cycle();
                n++;
            end while (!m_pushed && n < 20);
            if (!m_pushed) begin
                checks++; errors++;
                $error("FAIL full_fifo_push_timeout: got no accept expected accept");
            end
        end
        bus.game_wr_valid = 1'b0;
        bus.display_enabled = 1'b0;
        repeat (6) cycle();

        // Read-after-write: the read waits for the write to drain
        bus.display_enabled = 1'b1;
        bus.game_wr_valid = 1'b1;
        bus.game_wr_addr  = 10'd100;
        bus.game_wr_data  = 4'hA;
        cycle();
        bus.game_wr_valid = 1'b0;
        bus.game_rd_req   = 1'b1;
        bus.game_rd_addr  = 10'd100;
        n = 0;
        saw_ack = 0;
        while (!saw_ack && n < 20) begin
            if (n == 3) bus.display_enabled = 1'b0;
            cycle();
            n++;
        end
        if (saw_ack) chk("raw_data", bus.game_rd_data, 4'hA);
        else begin
            checks++; errors++;
            $error("FAIL raw_ack_timeout: got no ack expected ack");
        end
        bus.game_rd_req = 1'b0;
        cycle();

        // Priority collision in blanking: draw, then writes, then one game read
        bus.display_enabled = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.game_wr_valid = 1'b1;
            bus.game_wr_addr  = 10'(200 + i);
            bus.game_wr_data  = 4'(3 + i);
            cycle();
        end
        bus.game_wr_valid   = 1'b0;
        bus.display_enabled = 1'b0;
        bus.draw_rd_en      = 1'b1;
        bus.draw_rd_addr    = 10'd201;
        bus.game_rd_req     = 1'b1;
        bus.game_rd_addr    = 10'd201;
        ack_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) bus.draw_rd_en = 1'b0;
            cycle();
            if (saw_ack) bus.game_rd_req = 1'b0;
        end
        chk("collision_ack_once", ack_count, 1);

        // Async reset while in GRD_WAIT with a write queued
        bus.display_enabled = 1'b1;
        bus.game_rd_req     = 1'b1;
        bus.game_rd_addr    = 10'd50;
        bus.game_wr_valid   = 1'b1;
        bus.game_wr_addr    = 10'd60;
        bus.game_wr_data    = 4'h7;
        cycle();
        do_reset();
        bus.display_enabled = 1'b0;
        ack_count = 0;
        repeat (5) cycle();
        chk("reset_no_ack", ack_count, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) bus.display_enabled = ~bus.display_enabled;
            bus.draw_rd_en    = ($urandom_range(9) < 3);
            bus.draw_rd_addr  = 10'($urandom_range(1023));
            bus.game_wr_valid = ($urandom_range(9) < 4);
            bus.game_wr_addr  = 10'($urandom_range(63));
            bus.game_wr_data  = 4'($urandom);
            if (saw_ack) bus.game_rd_req = 1'b0;
            else if (!bus.game_rd_req && $urandom_range(4) == 0) begin
                bus.game_rd_req  = 1'b1;
                bus.game_rd_addr = 10'($urandom_range(63));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
